// File: rtl/viterbi_pkg.sv
// Shared widths and scheduler state encoding for the Viterbi frame scheduler.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package viterbi_pkg;

    // Length port width: frames are 1..N-1 long, so $clog2(N) bits suffice.
    function automatic int lw_f(input int n);
        return $clog2(n);
    endfunction

    function automatic int kw_f(input int k);
        return $clog2(k);
    endfunction

    function automatic int iw_f(input int i);
        return $clog2(i);
    endfunction

    // Requester id width never collapses to zero, even for a single requester.
    function automatic int rw_f(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        RESP
    } sched_state_e;

endpackage

// File: rtl/viterbi_frame_sched_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, cyclic search.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter
    import viterbi_pkg::*;
#(
    parameter int R = 2,
    localparam int RW = rw_f(R)
)
(
    input  logic [R-1:0]  req,
    input  logic [RW-1:0] ptr,
    output logic [R-1:0]  gnt,
    output logic [RW-1:0] gnt_id,
    output logic          gnt_vld
);

    // Walk the requests starting at ptr and keep the first hit.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = '0;
        gnt_id  = '0;
        gnt_vld = 1'b0;
        for (int i = 0; i < R; i++) begin
            idx = (int'(ptr) + i) % R;
            if (!gnt_vld && req[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = RW'(idx);
            end
        end
    end

endmodule

// File: rtl/viterbi_frame_sched.sv
// Shares one Viterbi core among R requesters: arbitrate, buffer a frame, replay it, return the path.
// Latency: last obs -> core_start +1 cycle; core_done -> resp_valid +1 cycle; all outputs registered.
// Backpressure: req_ready only for the owner during LOAD; resp_valid holds until resp_ready (VITERBI_SCHED_TIMEOUT_EN adds a core watchdog).
module viterbi_frame_sched
    import viterbi_pkg::*;
#(
    parameter int N   = 8,
    parameter int I   = 3,
    parameter int K   = 3,
    parameter int R   = 2,
    parameter int TMO = 64,
    localparam int LW = lw_f(N),
    localparam int KW = kw_f(K),
    localparam int IW = iw_f(I),
    localparam int RW = rw_f(R)
)
(
    input  logic            clk,
    input  logic            rst,
    input  logic [R-1:0]    req_valid,
    output logic [R-1:0]    req_ready,
    input  logic [R*KW-1:0] req_obs,
    input  logic [R-1:0]    req_last,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [RW-1:0]   resp_id,
    output logic [LW-1:0]   resp_len,
    output logic            resp_err,
    output logic [N*IW-1:0] resp_path,
    output logic            core_start,
    output logic [LW-1:0]   core_length,
    output logic [KW-1:0]   core_obs,
    output logic            core_obs_valid,
    input  logic [N*IW-1:0] core_path,
    input  logic            core_done,
    output logic            busy
);

    localparam logic [LW-1:0] CNT_MAX = LW'(N - 1);

    sched_state_e  state;
    logic [RW-1:0] gid;
    logic [RW-1:0] rr_ptr;
    logic [LW-1:0] cnt;
    logic [LW-1:0] idx;
    logic          ovf;
    logic [KW-1:0] obs_buf [N-1];

    logic [R-1:0]    arb_gnt;
    logic [RW-1:0]   arb_id;
    logic            arb_vld;
    logic            hs;
    logic            ovf_hit;
    logic [KW-1:0]   gobs;
    logic [KW-1:0]   first_obs;
    logic [LW-1:0]   cnt_nxt;
    logic [RW-1:0]   ptr_nxt;
    logic [N*IW-1:0] path_masked;

`ifdef VITERBI_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;
`endif

    rr_arbiter #(.R(R)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_id  (arb_id),
        .gnt_vld (arb_vld)
    );

    // Handshake with the current owner; cnt saturates at N-1 and any further beat marks overlength.
    assign hs        = req_valid[gid] & req_ready[gid];
    assign gobs      = req_obs[gid*KW +: KW];
    assign ovf_hit   = ovf | (cnt == CNT_MAX);
    assign cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign ptr_nxt   = (gid == RW'(R - 1)) ? '0 : gid + 1'b1;
    // A one-observation frame has not reached the buffer yet when ISSUE starts.
    assign first_obs = (cnt == '0) ? gobs : obs_buf[0];

    // Zero path entries beyond the frame length so stale core state never leaks out.
    always_comb begin
        path_masked = '0;
        for (int t = 0; t < N; t++) begin
            if (t < int'(cnt)) path_masked[t*IW +: IW] = core_path[t*IW +: IW];
        end
    end

    // Observation buffer: plain flops, written only while there is room.
    always_ff @(posedge clk) begin
        if (state == LOAD && hs && cnt != CNT_MAX) obs_buf[cnt] <= gobs;
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            gid            <= '0;
            rr_ptr         <= '0;
            cnt            <= '0;
            idx            <= '0;
            ovf            <= 1'b0;
            req_ready      <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= '0;
            resp_len       <= '0;
            resp_err       <= 1'b0;
            resp_path      <= '0;
            core_start     <= 1'b0;
            core_length    <= '0;
            core_obs       <= '0;
            core_obs_valid <= 1'b0;
            busy           <= 1'b0;
`ifdef VITERBI_SCHED_TIMEOUT_EN
            tmo_cnt        <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_vld) begin
                        gid       <= arb_id;
                        cnt       <= '0;
                        req_ready <= arb_gnt;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        cnt <= cnt_nxt;
                        if (ovf_hit) ovf <= 1'b1;
                        if (req_last[gid]) begin
                            req_ready <= '0;
                            if (ovf_hit) begin
                                resp_valid <= 1'b1;
                                resp_id    <= gid;
                                resp_len   <= cnt_nxt;
                                resp_err   <= 1'b1;
                                resp_path  <= '0;
                                state      <= RESP;
                            end else begin
                                core_start     <= 1'b1;
                                core_obs_valid <= 1'b1;
                                core_obs       <= first_obs;
                                core_length    <= cnt_nxt;
                                idx            <= LW'(1);
                                state          <= ISSUE;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (idx == cnt) begin
                        core_obs_valid <= 1'b0;
                        core_obs       <= '0;
                        state          <= WAIT;
`ifdef VITERBI_SCHED_TIMEOUT_EN
                        tmo_cnt        <= '0;
`endif
                    end else begin
                        core_obs <= obs_buf[idx];
                        idx      <= idx + 1'b1;
                    end
                end
                WAIT: begin
                    if (core_done) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= gid;
                        resp_len    <= cnt;
                        resp_err    <= 1'b0;
                        resp_path   <= path_masked;
                        core_length <= '0;
                        state       <= RESP;
                    end
`ifdef VITERBI_SCHED_TIMEOUT_EN
                    else if (tmo_cnt == TW'(TMO - 1)) begin
                        resp_valid  <= 1'b1;
                        resp_id     <= gid;
                        resp_len    <= cnt;
                        resp_err    <= 1'b1;
                        resp_path   <= '0;
                        core_length <= '0;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= ptr_nxt;
                        ovf        <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_frame_sched.sv
// Bench for viterbi_frame_sched: directed frames, echoing core model, scoreboard on the response channel.
// Latency: n/a.
// Backpressure: exercised by holding resp_ready low.
module tb_viterbi_frame_sched;

    localparam int N  = 8;
    localparam int I  = 3;
    localparam int K  = 3;
    localparam int R  = 2;
    localparam int LW = $clog2(N);
    localparam int KW = $clog2(K);
    localparam int IW = $clog2(I);
    localparam int RW = 1;
`ifdef VITERBI_SCHED_TIMEOUT_EN
    localparam int TMO_P = 16;
`else
    localparam int TMO_P = 64;
`endif

    typedef int frame_t [8];
    typedef struct {
        logic [RW-1:0]   id;
        logic [LW-1:0]   len;
        logic            err;
        logic [N*IW-1:0] path;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [R-1:0]    req_valid;
    logic [R-1:0]    req_ready;
    logic [R*KW-1:0] req_obs;
    logic [R-1:0]    req_last;
    logic            resp_valid;
    logic            resp_ready;
    logic [RW-1:0]   resp_id;
    logic [LW-1:0]   resp_len;
    logic            resp_err;
    logic [N*IW-1:0] resp_path;
    logic            core_start;
    logic [LW-1:0]   core_length;
    logic [KW-1:0]   core_obs;
    logic            core_obs_valid;
    logic [N*IW-1:0] core_path;
    logic            core_done;
    logic            busy;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    exp_t sb[$];
    int   gq[$];
    int   oh_err = 0;
    int   gap_err = 0;
    int   len_err = 0;
    int   n_starts = 0;
    int   m_start_cyc = 0;
    int   m_len = 0;
    int   m_k = 0;
    int   m_dly = -1;
    int   m_obs [8];
    bit   core_hang = 0;

    viterbi_frame_sched #(.N(N), .I(I), .K(K), .R(R), .TMO(TMO_P)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_obs        (req_obs),
        .req_last       (req_last),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_len       (resp_len),
        .resp_err       (resp_err),
        .resp_path      (resp_path),
        .core_start     (core_start),
        .core_length    (core_length),
        .core_obs       (core_obs),
        .core_obs_valid (core_obs_valid),
        .core_path      (core_path),
        .core_done      (core_done),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({req_ready, resp_valid, resp_id, resp_len, resp_err, resp_path,
                    core_start, core_length, core_obs, core_obs_valid, busy});
    endfunction

    function automatic logic [N*IW-1:0] exp_path(input frame_t f, input int n);
        logic [N*IW-1:0] p;
        p = '0;
        for (int t = 0; t < n && t < N; t++) p[t*IW +: IW] = IW'(f[t]);
        return p;
    endfunction

    // Requester driver: presents one frame, pushes the expected response at its last handshake.
    task automatic send_frame(input int r, input frame_t f, input int n, input bit push, input bit err_exp);
        int   i;
        int   guard;
        exp_t e;
        i = 0;
        guard = 0;
        while (i < n && guard < 300) begin
            req_valid[r]          = 1'b1;
            req_obs[r*KW +: KW]   = KW'(f[i]);
            req_last[r]           = (i == n - 1);
            if (req_ready[r]) begin
                if (i == n - 1) begin
                    last_cyc = cyc;
                    if (push) begin
                        e.id   = RW'(r);
                        e.len  = (n >= N) ? LW'(N - 1) : LW'(n);
                        e.err  = err_exp || (n >= N);
                        e.path = e.err ? '0 : exp_path(f, n);
                        sb.push_back(e);
                    end
                end
                i++;
            end
            tick;
            guard++;
        end
        req_valid[r] = 1'b0;
        req_last[r]  = 1'b0;
        check($sformatf("drv_accept_r%0d", r), 64'(i), 64'(n));
    endtask

    task automatic wait_idle;
        int g;
        g = 0;
        while ((sb.size() != 0 || busy) && g < 1000) begin
            tick;
            g++;
        end
        check("drain_timeout", 64'(g < 1000), 64'(1));
    endtask

    // Core model: records the burst and echoes the observations back as the path.
    initial begin
        core_done = 1'b0;
        core_path = '0;
        forever begin
            tick;
            if (!core_hang) core_done = 1'b0;
            if (rst) begin
                m_k   = 0;
                m_dly = -1;
            end else begin
                if (m_dly >= 0 && int'(core_length) != m_len) len_err++;
                if (m_dly > 0) begin
                    m_dly--;
                    if (m_dly == 0) begin
                        m_dly = -1;
                        if (!core_hang) begin
                            core_path = '1;
                            for (int t = 0; t < m_len && t < 8; t++) core_path[t*IW +: IW] = IW'(m_obs[t]);
                            core_done = 1'b1;
                        end
                    end
                end
                if (core_start) begin
                    m_k         = 0;
                    m_len       = int'(core_length);
                    m_start_cyc = cyc;
                    n_starts++;
                end
                if (core_obs_valid) begin
                    if (m_k < 8) m_obs[m_k] = int'(core_obs);
                    m_k++;
                    if (m_k == m_len) m_dly = 3;
                end else if (m_k > 0 && m_k < m_len) begin
                    gap_err++;
                end
            end
        end
    end

    // Scoreboard monitor: compares every accepted response against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_resp", 64'(1), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 64'(resp_id), 64'(e.id));
                    check("resp_len", 64'(resp_len), 64'(e.len));
                    check("resp_err", 64'(resp_err), 64'(e.err));
                    check("resp_path", 64'(resp_path), 64'(e.path));
                end
            end
        end
    end

    // Grant-order and ownership monitor.
    initial begin
        logic [R-1:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < R; r++) if (req_ready[r] && !prev[r]) gq.push_back(r);
            if ($countones(req_ready) > 1) oh_err++;
            prev = req_ready;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got %0d tests, expected completion", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int            g;
        int            h;
        int            st0;
        logic [63:0]   snap;
        int            bp_err;
        logic [15:0]   seq;
        rst        = 1'b1;
        req_valid  = '0;
        req_obs    = '0;
        req_last   = '0;
        resp_ready = 1'b1;
        repeat (3) tick;
        check("reset_outputs", outs(), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        tick;

        // Single frame from requester 0.
        send_frame(0, '{0, 0, 1, 1, 2, 0, 0, 0}, 5, 1, 0);
        wait_idle;
        check("t1_start_latency", 64'(m_start_cyc - last_cyc), 64'(1));
        check("t1_core_length", 64'(m_len), 64'(5));
        seq = '0;
        for (int t = 0; t < 5; t++) seq[t*2 +: 2] = 2'(m_obs[t]);
        check("t1_obs_sequence", 64'(seq), 64'h250);

        // Overlength from requester 1: all eight accepted, no core run.
        st0 = n_starts;
        send_frame(1, '{0, 1, 2, 0, 1, 2, 0, 1}, 8, 1, 0);
        wait_idle;
        check("ovf_no_core_start", 64'(n_starts - st0), 64'(0));

        // Fairness: both requesters keep frames pending.
        gq.delete();
        fork
            begin
                send_frame(0, '{1, 2, 0, 0, 0, 0, 0, 0}, 3, 1, 0);
                send_frame(0, '{2, 2, 0, 0, 0, 0, 0, 0}, 2, 1, 0);
            end
            begin
                send_frame(1, '{0, 1, 0, 0, 0, 0, 0, 0}, 2, 1, 0);
                send_frame(1, '{1, 1, 1, 2, 0, 0, 0, 0}, 4, 1, 0);
            end
        join
        wait_idle;
        check("fair_order", (gq.size() == 4) ? 64'({4'(gq[0]), 4'(gq[1]), 4'(gq[2]), 4'(gq[3])}) : 64'hdead,
              64'h0101);

        // Response backpressure with requester 1 waiting.
        resp_ready = 1'b0;
        send_frame(0, '{2, 1, 0, 0, 0, 0, 0, 0}, 2, 1, 0);
        fork
            send_frame(1, '{1, 0, 2, 0, 0, 0, 0, 0}, 3, 1, 0);
        join_none
        g = 0;
        while (!resp_valid && g < 200) begin
            tick;
            g++;
        end
        check("bp_resp_seen", 64'(resp_valid), 64'(1));
        snap   = 64'({resp_id, resp_len, resp_err, resp_path});
        bp_err = 0;
        repeat (10) begin
            tick;
            if (!resp_valid || 64'({resp_id, resp_len, resp_err, resp_path}) != snap || req_ready != '0) bp_err++;
        end
        check("bp_stable", 64'(bp_err), 64'(0));
        resp_ready = 1'b1;
        h = cyc;
        g = 0;
        while (!req_ready[1] && g < 20) begin
            tick;
            g++;
        end
        check("bp_ready_delay", 64'(cyc - h), 64'(2));
        wait_idle;

        // Reset during the third issue cycle.
        send_frame(0, '{1, 2, 0, 1, 2, 0, 0, 0}, 5, 0, 0);
        check("rst_first_issue_start", 64'(core_start), 64'(1));
        tick;
        tick;
        rst = 1'b1;
        gq.delete();
        tick;
        check("rst_midissue_outputs", outs(), 64'(0));
        check("rst_midissue_busy", 64'(busy), 64'(0));
        tick;
        rst = 1'b0;
        send_frame(1, '{2, 0, 1, 0, 0, 0, 0, 0}, 3, 1, 0);
        wait_idle;
        check("rst_first_grant_r1", (gq.size() >= 1) ? 64'(gq[0]) : 64'hdead, 64'(1));

`ifdef VITERBI_SCHED_TIMEOUT_EN
        // Watchdog: core never finishes.
        core_hang  = 1'b1;
        core_done  = 1'b0;
        resp_ready = 1'b0;
        send_frame(0, '{1, 1, 0, 0, 0, 0, 0, 0}, 2, 1, 1);
        g = 0;
        while (!resp_valid && g < 200) begin
            tick;
            g++;
        end
        check("tmo_latency", 64'(cyc - m_start_cyc), 64'(2 + 16));
        core_path = '1;
        core_done = 1'b1;
        tick;
        core_done = 1'b0;
        tick;
        check("tmo_late_done_err", 64'(resp_err), 64'(1));
        check("tmo_late_done_path", 64'(resp_path), 64'(0));
        check("tmo_late_done_valid", 64'(resp_valid), 64'(1));
        resp_ready = 1'b1;
        wait_idle;
        core_hang = 1'b0;
`endif

        repeat (5) tick;
        check("ready_onehot", 64'(oh_err), 64'(0));
        check("core_obs_gapfree", 64'(gap_err), 64'(0));
        check("core_length_hold", 64'(len_err), 64'(0));
        check("sb_leftover", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
